stopwatch_core: RTL and testbench
=================================

// Module: stopwatch_core
// PURPOSE
//  Stopwatch timekeeping core. Produces four BCD digits MM:SS (d3 d2 : d1 d0) for the
//  downstream 7-segment multiplexer. Supports run/pause, clear and manual field adjust.
//  Inputs are one-cycle pulses or levels from the debounce stage, synchronous to CLK.
// PARAMETERS
//  DIV_SEC    100_000_000  CLK cycles per 1 s count tick
//  DIV_ADJ     50_000_000  CLK cycles per adjust-increment tick (2 Hz)
//  DIV_BLINK   25_000_000  CLK cycles per blink phase toggle (ADJ_BLINK_EN only)
// PORTS
//  CLK         in   1  system clock, all logic on posedge
//  RESET_N     in   1  asynchronous, active-low reset
//  START_STOP  in   1  1-cycle pulse: toggles run/pause
//  CLEAR       in   1  1-cycle pulse: zero time, go IDLE
//  ADJ         in   1  level: request adjust mode
//  SEL         in   1  level: adjust field, 0 = seconds, 1 = minutes
//  d0          out  4  seconds ones, BCD 0-9
//  d1          out  4  seconds tens, BCD 0-5
//  d2          out  4  minutes ones, BCD 0-9
//  d3          out  4  minutes tens, BCD 0-5
//  RUNNING     out  1  high while state == RUN
//  ROLLOVER    out  1  1-cycle pulse on wrap 59:59 -> 00:00
// BEHAVIOUR
//  - Reset (RESET_N low, async): state IDLE, all digits 0, prescalers 0,
//    RUNNING 0, ROLLOVER 0, blink phase 0. Release is synchronous to the next CLK edge.
//  - States: IDLE, RUN, PAUSE, ADJUST. Input priority per cycle: CLEAR > ADJ > START_STOP.
//  - CLEAR (any state): next cycle digits 00:00, state IDLE, all prescalers 0.
//    CLEAR wins over a simultaneous tick.
//  - IDLE:   START_STOP -> RUN. ADJ high -> ADJUST.
//  - RUN:    START_STOP -> PAUSE. ADJ ignored.
//  - PAUSE:  START_STOP -> RUN. ADJ high -> ADJUST.
//  - ADJUST: ADJ low -> PAUSE. START_STOP ignored.
//  - Second prescaler: counts only in RUN and holds its value in PAUSE, so a
//    partial second resumes. Tick when count == DIV_SEC-1; count then wraps to 0.
//    Digits update on the edge that ends the tick cycle (1-cycle latency, registered).
//  - Count: d0 9->0 carries to d1; d1 5->0 carries to d2; d2 9->0 carries to d3;
//    d3 5->0. At 59:59 a tick gives 00:00, ROLLOVER high for that one cycle,
//    and the state stays RUN.
//  - Adjust prescaler: cleared on ADJUST entry; tick when it reaches DIV_ADJ-1.
//    Each tick increments the selected field mod 60 (BCD pair d1:d0 or d3:d2).
//    No carry into the other field. A SEL change takes effect on the next tick.
//  - Digits are always valid BCD in registers; no state ever stores an out-of-range value.
//  - Out-of-range parameters (0 or 1) are unsupported.
// CONFIGURATION
//  ADJ_BLINK_EN defined: a blink prescaler runs only in ADJUST, cleared on entry, and
//    toggles the blink phase every DIV_BLINK cycles. While the phase is 1, both digits
//    of the selected field are driven as 4'hF (blank/dash downstream); register
//    contents are unchanged. Outside ADJUST the outputs show the true digits.
//  ADJ_BLINK_EN undefined: no blink logic; outputs always equal the digit registers.
// TESTING  (DIV_SEC=10, DIV_ADJ=4, DIV_BLINK=2)
//  1. Reset, pulse START_STOP, run 10 cycles -> d0=1, RUNNING=1; after 600 cycles -> 01:00.
//  2. ADJ=1 SEL=0 for 59 adj ticks, SEL=1 for 59 adj ticks, ADJ=0 -> 59:59, state PAUSE;
//     START_STOP, 10 cycles -> 00:00, ROLLOVER 1 cycle, RUNNING stays 1.
//  3. Run 15 cycles (00:01, prescaler=5), START_STOP, wait 50 cycles -> still 00:01;
//     START_STOP, 5 cycles -> 00:02.
//  4. CLEAR coincident with a tick at 00:09 -> 00:00 next cycle, RUNNING=0, no ROLLOVER.
//  5. ADJ=1 while RUN -> still RUN and counting; async RESET_N low mid-count -> all 0 at once.
//  6. ADJ_BLINK_EN, ADJUST SEL=1 at 12:34 -> d3,d2 alternate 1,2 / F,F every 2 cycles;
//     d1,d0 stay 3,4.

Source files
------------

// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping core: BCD MM:SS with run/pause, clear and manual field adjust.
// Optional build macro ADJ_BLINK_EN blanks the selected field at DIV_BLINK rate in ADJUST.
module stopwatch_core #(
  parameter int unsigned DIV_SEC   = 100_000_000,
  parameter int unsigned DIV_ADJ   = 50_000_000,
  parameter int unsigned DIV_BLINK = 25_000_000
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       START_STOP,
  input  logic       CLEAR,
  input  logic       ADJ,
  input  logic       SEL,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic       RUNNING,
  output logic       ROLLOVER
);

  localparam int unsigned SEC_W = $clog2(DIV_SEC);
  localparam int unsigned ADJ_W = $clog2(DIV_ADJ);
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(DIV_SEC - 1);
  localparam logic [ADJ_W-1:0] ADJ_LAST = ADJ_W'(DIV_ADJ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_ADJUST
  } state_e;

  state_e             state_q, state_d;
  logic [SEC_W-1:0]   sec_cnt_q, sec_cnt_d;
  logic [ADJ_W-1:0]   adj_cnt_q, adj_cnt_d;
  logic [7:0]         secs_q, secs_d;   // {tens, ones} BCD
  logic [7:0]         mins_q, mins_d;
  logic               rollover_q, rollover_d;
  logic               sec_tick, adj_tick;
  logic               blank_sec, blank_min;

  function automatic logic [7:0] bcd60_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: CLEAR > ADJ > START_STOP
  always_comb begin
    state_d = state_q;
    if (CLEAR) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:   if (ADJ) state_d = S_ADJUST; else if (START_STOP) state_d = S_RUN;
        S_RUN:    if (START_STOP) state_d = S_PAUSE;
        S_PAUSE:  if (ADJ) state_d = S_ADJUST; else if (START_STOP) state_d = S_RUN;
        S_ADJUST: if (!ADJ) state_d = S_PAUSE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  assign sec_tick = (state_q == S_RUN)    && (sec_cnt_q == SEC_LAST);
  assign adj_tick = (state_q == S_ADJUST) && (adj_cnt_q == ADJ_LAST);

  // Datapath: the second prescaler holds outside RUN so a paused partial second resumes;
  // the adjust prescaler sits at zero outside ADJUST, which clears it on entry.
  always_comb begin
    sec_cnt_d  = sec_cnt_q;
    adj_cnt_d  = '0;
    secs_d     = secs_q;
    mins_d     = mins_q;
    rollover_d = 1'b0;
    if (CLEAR) begin
      sec_cnt_d = '0;
      secs_d    = '0;
      mins_d    = '0;
    end else begin
      if (state_q == S_RUN)
        sec_cnt_d = sec_tick ? '0 : sec_cnt_q + SEC_W'(1);
      if ((state_q == S_ADJUST) && !adj_tick)
        adj_cnt_d = adj_cnt_q + ADJ_W'(1);
      if (sec_tick) begin
        secs_d = bcd60_inc(secs_q);
        if (secs_q == 8'h59) begin
          mins_d     = bcd60_inc(mins_q);
          rollover_d = (mins_q == 8'h59);
        end
      end
      if (adj_tick) begin
        if (SEL) mins_d = bcd60_inc(mins_q);
        else     secs_d = bcd60_inc(secs_q);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sec_cnt_q  <= '0;
      adj_cnt_q  <= '0;
      secs_q     <= '0;
      mins_q     <= '0;
      rollover_q <= 1'b0;
    end else begin
      sec_cnt_q  <= sec_cnt_d;
      adj_cnt_q  <= adj_cnt_d;
      secs_q     <= secs_d;
      mins_q     <= mins_d;
      rollover_q <= rollover_d;
    end
  end

`ifdef ADJ_BLINK_EN
  localparam int unsigned BLK_W = $clog2(DIV_BLINK);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(DIV_BLINK - 1);

  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_q, blink_d;

  always_comb begin
    blink_cnt_d = '0;
    blink_d     = 1'b0;
    if (!CLEAR && (state_q == S_ADJUST)) begin
      if (blink_cnt_q == BLK_LAST) begin
        blink_d = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
        blink_d     = blink_q;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  // Gate with state: blink_q may still be set for the first cycle after leaving ADJUST.
  assign blank_sec = blink_q && (state_q == S_ADJUST) && !SEL;
  assign blank_min = blink_q && (state_q == S_ADJUST) &&  SEL;
`else
  // DIV_BLINK only matters when blinking is built in.
  logic unused_div_blink;
  assign unused_div_blink = ^DIV_BLINK;
  assign blank_sec = 1'b0;
  assign blank_min = 1'b0;
`endif

  // Output logic
  always_comb begin
    d0       = blank_sec ? 4'hF : secs_q[3:0];
    d1       = blank_sec ? 4'hF : secs_q[7:4];
    d2       = blank_min ? 4'hF : mins_q[3:0];
    d3       = blank_min ? 4'hF : mins_q[7:4];
    RUNNING  = (state_q == S_RUN);
    ROLLOVER = rollover_q;
  end

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core: vector table plus hand sequences for
// async reset and the adjust-mode display, checked through an expectation queue.
module tb_stopwatch_core;

  localparam int unsigned DIV_SEC   = 10;
  localparam int unsigned DIV_ADJ   = 4;
  localparam int unsigned DIV_BLINK = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ss = 1'b0, clr = 1'b0, adj = 1'b0, sel = 1'b0;
  logic [3:0] d0, d1, d2, d3;
  logic       running, rollover;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  stopwatch_core #(
    .DIV_SEC  (DIV_SEC),
    .DIV_ADJ  (DIV_ADJ),
    .DIV_BLINK(DIV_BLINK)
  ) dut (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .START_STOP(ss),
    .CLEAR     (clr),
    .ADJ       (adj),
    .SEL       (sel),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .RUNNING   (running),
    .ROLLOVER  (rollover)
  );

  typedef struct {
    string       name;
    logic        ss, clr, adj, sel;
    int unsigned cyc;
    logic [15:0] d;
    logic        run, ro;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] d;
    logic        run, ro;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];

  task automatic add(input string name, input logic s, input logic c, input logic a,
                     input logic se, input int unsigned cyc, input logic [15:0] d,
                     input logic run, input logic ro);
    vec_t v;
    v.name = name; v.ss = s; v.clr = c; v.adj = a; v.sel = se;
    v.cyc = cyc; v.d = d; v.run = run; v.ro = ro;
    tbl.push_back(v);
  endtask

  task automatic expect_out(input string name, input logic [15:0] d, input logic run,
                            input logic ro);
    exp_t e;
    e.name = name; e.d = d; e.run = run; e.ro = ro;
    sbq.push_back(e);
  endtask

  task automatic check_head();
    exp_t        e;
    logic [15:0] got;
    n_checks++;
    if (sbq.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got no expectation, required one queued");
    end else begin
      e   = sbq.pop_front();
      got = {d3, d2, d1, d0};
      if (got !== e.d || running !== e.run || rollover !== e.ro) begin
        n_fail++;
        $display("FAIL %s: got %h run=%b ro=%b, required %h run=%b ro=%b",
                 e.name, got, running, rollover, e.d, e.run, e.ro);
      end
    end
  endtask

  task automatic drive_for(input logic s, input logic c, input logic a, input logic se,
                           input int unsigned cyc);
    ss = s; clr = c; adj = a; sel = se;
    @(negedge clk);
    ss = 1'b0; clr = 1'b0;
    for (int unsigned i = 1; i < cyc; i++) @(negedge clk);
  endtask

  task automatic apply(input vec_t v);
    expect_out(v.name, v.d, v.run, v.ro);
    drive_for(v.ss, v.clr, v.adj, v.sel, v.cyc);
    check_head();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] blink_exp[5];

    //   name              ss clr adj sel cyc    MMSS     run ro
    add("start",           1, 0, 0, 0,   1, 16'h0000, 1, 0);
    add("first_sec",       0, 0, 0, 0,  10, 16'h0001, 1, 0);
    add("one_min",         0, 0, 0, 0, 590, 16'h0100, 1, 0);
    add("adj_in_run",      0, 0, 1, 0,  10, 16'h0101, 1, 0);
    add("clear",           0, 1, 0, 0,   1, 16'h0000, 0, 0);
    add("adj_enter",       0, 0, 1, 0,   1, 16'h0000, 0, 0);
    add("adj_sec59",       0, 0, 1, 0, 236, 16'h0059, 0, 0);
    add("adj_sec_wrap",    0, 0, 1, 0,   4, 16'h0000, 0, 0);
    add("adj_sec59b",      0, 0, 1, 0, 236, 16'h0059, 0, 0);
    add("adj_min59",       0, 0, 1, 1, 236, 16'h5959, 0, 0);
    add("adj_exit",        0, 0, 0, 0,   1, 16'h5959, 0, 0);
    add("resume",          1, 0, 0, 0,   1, 16'h5959, 1, 0);
    add("rollover",        0, 0, 0, 0,  10, 16'h0000, 1, 1);
    add("rollover_end",    0, 0, 0, 0,   1, 16'h0000, 1, 0);
    add("clear2",          0, 1, 0, 0,   1, 16'h0000, 0, 0);
    add("start2",          1, 0, 0, 0,   1, 16'h0000, 1, 0);
    add("run15",           0, 0, 0, 0,  15, 16'h0001, 1, 0);
    add("pause_hold",      1, 0, 0, 0,  50, 16'h0001, 0, 0);
    add("resume_partial",  1, 0, 0, 0,   4, 16'h0001, 1, 0);
    add("partial_done",    0, 0, 0, 0,   1, 16'h0002, 1, 0);
    add("to_09",           0, 0, 0, 0,  70, 16'h0009, 1, 0);
    add("pre_tick",        0, 0, 0, 0,   9, 16'h0009, 1, 0);
    add("clear_on_tick",   0, 1, 0, 0,   1, 16'h0000, 0, 0);
    add("idle_hold",       0, 0, 0, 0,  20, 16'h0000, 0, 0);
    add("adj_over_ss",     1, 0, 1, 0,   5, 16'h0001, 0, 0);
    add("adj_ignores_ss",  1, 0, 1, 0,   4, 16'h0002, 0, 0);
    add("clear_over_adj",  0, 1, 1, 0,   1, 16'h0000, 0, 0);
    add("adj_after_clear", 0, 0, 1, 0,   5, 16'h0001, 0, 0);
    add("pause_from_adj",  0, 0, 0, 0,   1, 16'h0001, 0, 0);
    add("pause_start",     1, 0, 0, 0,  10, 16'h0001, 1, 0);
    add("pause_start_tick",0, 0, 0, 0,   1, 16'h0002, 1, 0);
    add("pre_reset",       0, 0, 0, 0,  13, 16'h0003, 1, 0);

    repeat (2) @(negedge clk);
    expect_out("in_reset", 16'h0000, 1'b0, 1'b0);
    check_head();
    rst_n = 1'b1;
    @(negedge clk);
    expect_out("reset_release", 16'h0000, 1'b0, 1'b0);
    check_head();

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Asynchronous reset mid-count, sampled before any further clock edge
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    expect_out("async_reset", 16'h0000, 1'b0, 1'b0);
    check_head();
    @(negedge clk);
    rst_n = 1'b1;
    begin
      vec_t v;
      v.name = "post_reset"; v.ss = 0; v.clr = 0; v.adj = 0; v.sel = 0;
      v.cyc = 3; v.d = 16'h0000; v.run = 0; v.ro = 0;
      apply(v);
    end

    // Reach 12:34 through adjust, then re-enter ADJUST on minutes
    drive_for(1'b0, 1'b0, 1'b1, 1'b1, 49);
    drive_for(1'b0, 1'b0, 1'b1, 1'b0, 136);
    begin
      vec_t v;
      v.name = "adj_1234"; v.ss = 0; v.clr = 0; v.adj = 0; v.sel = 0;
      v.cyc = 1; v.d = 16'h1234; v.run = 0; v.ro = 0;
      apply(v);
    end
`ifdef ADJ_BLINK_EN
    blink_exp = '{16'h1234, 16'h1234, 16'hFF34, 16'hFF34, 16'h1334};
`else
    blink_exp = '{16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1334};
`endif
    adj = 1'b1; sel = 1'b1;
    for (int k = 0; k < 5; k++) begin
      expect_out($sformatf("adj_min_view%0d", k), blink_exp[k], 1'b0, 1'b0);
      @(negedge clk);
      check_head();
    end
    adj = 1'b0;
    expect_out("adj_min_exit", 16'h1334, 1'b0, 1'b0);
    @(negedge clk);
    check_head();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
